// File: rtl/imem_boot_loader_if.sv
// Word-stream handshake and instruction-memory byte write port of the boot loader.
// slave = loader side, master = host / memory side.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [31:0]       word_in;
  logic              word_valid;
  logic              word_last;
  logic              word_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output word_in, word_valid, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  word_in, word_valid, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: accepts 32-bit words, writes each as four big-endian bytes into
// instruction memory, then releases the CPU pipeline.
module imem_boot_loader #(
  parameter int unsigned MEM_BYTES = 48,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_boot_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  // Pointer must be able to hold MEM_BYTES itself to detect the full condition.
  localparam int unsigned PTR_W = $clog2(MEM_BYTES + 1);

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERR} state_t;

  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic             last_q, last_d;
  logic [1:0]       idx_q, idx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] ptr_inc;
  logic [7:0]       byte_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= 2'd0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    ptr_inc = ptr_q + PTR_W'(4);
    byte_d  = 8'd0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = ACCEPT;
          ptr_d   = '0;
        end
      end
      ACCEPT: begin
        if (bus.word_valid && bus.word_ready) begin
          word_d  = bus.word_in;
          last_d  = bus.word_last;
          idx_d   = 2'd0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          ptr_d = ptr_inc;
          // A last word landing in the final slot completes rather than overflows.
          if (last_q) begin
            state_d = DONE;
          end else if (ptr_inc == PTR_W'(MEM_BYTES)) begin
            state_d = ERR;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (idx_d)
      2'd0:    byte_d = word_d[31:24];
      2'd1:    byte_d = word_d[23:16];
      2'd2:    byte_d = word_d[15:8];
      default: byte_d = word_d[7:0];
    endcase
  end

  // Outputs are registered decodes of the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.word_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      cpu_hold       <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      bus.word_ready <= (state_d == ACCEPT);
      bus.mem_we     <= (state_d == WRITE);
      bus.mem_addr   <= (state_d == WRITE) ? ADDR_W'(ptr_d + PTR_W'(idx_d)) : '0;
      bus.mem_wdata  <= (state_d == WRITE) ? byte_d : 8'd0;
      cpu_hold       <= (state_d != DONE);
      done           <= (state_d == DONE);
      error          <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a byte-level
// memory model built from the word stream.
module tb_imem_boot_loader;

  localparam int unsigned MEM_BYTES = 48;
  localparam int unsigned ADDR_W    = 32;
  localparam int ST_IDLE = 0;
  localparam int ST_ACC  = 1;
  localparam int ST_DONE = 2;
  localparam int ST_ERR  = 3;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold;
  logic done;
  logic error;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bus     (bus),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] tb_mem  [MEM_BYTES];
  logic [7:0] exp_mem [MEM_BYTES];
  int         exp_addr_q[$];
  logic [7:0] exp_data_q[$];
  int         m_ptr;
  int         m_st;
  bit         mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Instruction memory stand-in: records every write and matches it to the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_we === 1'b1) begin
        check("write_expected", 64'(exp_addr_q.size() != 0), 64'd1);
        check("addr_range", 64'(bus.mem_addr < MEM_BYTES), 64'd1);
        if (exp_addr_q.size() != 0) begin
          check("mem_addr", 64'(bus.mem_addr), 64'(exp_addr_q.pop_front()));
          check("mem_wdata", 64'(bus.mem_wdata), 64'(exp_data_q.pop_front()));
        end
        if (bus.mem_addr < MEM_BYTES) tb_mem[int'(bus.mem_addr)] = bus.mem_wdata;
      end else begin
        check("idle_bus", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'd0);
      end
    end
  end

  // Reference: a word at pointer p fills p..p+3 big-endian; nb<4 models a cut-short word.
  task automatic model_word(input logic [31:0] w, input logic l, input int nb);
    logic [7:0] b;
    for (int k = 0; k < nb; k++) begin
      b = 8'(w >> (24 - 8 * k));
      if (m_ptr + k < int'(MEM_BYTES)) begin
        exp_addr_q.push_back(m_ptr + k);
        exp_data_q.push_back(b);
        exp_mem[m_ptr + k] = b;
      end
    end
    if (nb == 4) begin
      m_ptr += 4;
      if (l) m_st = ST_DONE;
      else if (m_ptr >= int'(MEM_BYTES)) m_st = ST_ERR;
      else m_st = ST_ACC;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ready"}, 64'(bus.word_ready), 64'(m_st == ST_ACC));
    check({tag, "_done"},  64'(done),           64'(m_st == ST_DONE));
    check({tag, "_error"}, 64'(error),          64'(m_st == ST_ERR));
    check({tag, "_hold"},  64'(cpu_hold),       64'(m_st != ST_DONE));
  endtask

  // Returns at the negedge of the first cycle after the handshake edge.
  task automatic handshake(input logic [31:0] w, input logic l, input int nb);
    int waited = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    while (bus.word_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", 64'(waited < 100), 64'd1);
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    bus.word_last  = l;
    model_word(w, l, nb);
    @(negedge clk);
    bus.word_valid = 1'b0;
    bus.word_in    = $urandom;
    bus.word_last  = 1'($urandom);
    check("ready_low_in_write", 64'(bus.word_ready), 64'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    handshake(w, l, 4);
    repeat (3) @(negedge clk);
    check("done_early", 64'(done), 64'd0);
    @(negedge clk);
    check("writes_drained", 64'(exp_addr_q.size()), 64'd0);
    check_status("after_word");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (m_st != ST_ACC) begin
      m_st  = ST_ACC;
      m_ptr = 0;
    end
    check_status("after_start");
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    start          = 1'b0;
    bus.word_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_st  = ST_IDLE;
    m_ptr = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    check_status("reset");
  endtask

  task automatic compare_mem();
    for (int i = 0; i < int'(MEM_BYTES); i++)
      check($sformatf("mem[%0d]", i), 64'(tb_mem[i]), 64'(exp_mem[i]));
  endtask

  logic [31:0] prog [12] = '{
    32'h8C010000, 32'h8C020004, 32'h00221820, 32'hAC030008,
    32'h8C04000C, 32'h00832820, 32'hAC050010, 32'h8C060014,
    32'h00C53820, 32'hAC070018, 32'h8C0B0020, 32'hAC0B0028
  };

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      tb_mem[i]  = 8'd0;
      exp_mem[i] = 8'd0;
    end
    do_reset();
    mon_en = 1'b1;

    // Single word
    pulse_start();
    send_word(32'h8C100000, 1'b1);
    compare_mem();

    // Full 12-word program ending in the final slot
    pulse_start();
    for (int i = 0; i < 12; i++) send_word(prog[i], 1'(i == 11));
    check("b44", 64'(tb_mem[44]), 64'hAC);
    check("b45", 64'(tb_mem[45]), 64'h0B);
    check("b46", 64'(tb_mem[46]), 64'h00);
    check("b47", 64'(tb_mem[47]), 64'h28);
    compare_mem();

    // Reload after DONE; upper bytes must survive
    pulse_start();
    send_word(32'h02114020, 1'b1);
    compare_mem();

    // Stalled source with an ignored start in ACCEPT
    pulse_start();
    send_word($urandom, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("stall_we", 64'(bus.mem_we), 64'd0);
      check("stall_ready", 64'(bus.word_ready), 64'd1);
      if (i == 3) pulse_start();
    end
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    compare_mem();

    // Overflow: 12 words without last, a 13th must never be taken
    pulse_start();
    for (int i = 0; i < 12; i++) send_word($urandom, 1'b0);
    bus.word_in    = $urandom;
    bus.word_valid = 1'b1;
    bus.word_last  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ovf_ready", 64'(bus.word_ready), 64'd0);
      check("ovf_error", 64'(error), 64'd1);
    end
    bus.word_valid = 1'b0;
    compare_mem();
    pulse_start();
    send_word($urandom, 1'b1);
    compare_mem();

    // Reset during the second word after byte index 1
    pulse_start();
    send_word($urandom, 1'b0);
    handshake($urandom, 1'b0, 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_we", 64'(bus.mem_we), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(bus.word_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_st  = ST_IDLE;
    m_ptr = 0;
    check("rst_leftover_writes", 64'(exp_addr_q.size()), 64'd0);
    check_status("post_reset");
    compare_mem();
    pulse_start();
    send_word($urandom, 1'b1);
    compare_mem();

    // Reset and start together: reset wins
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    m_st  = ST_IDLE;
    m_ptr = 0;
    check_status("rst_start");
    @(negedge clk);
    check_status("rst_start_idle");

    // Random programs
    for (int p = 0; p < 4; p++) begin
      int len;
      len = int'($urandom_range(1, 12));
      pulse_start();
      for (int i = 0; i < len; i++) send_word($urandom, 1'(i == len - 1));
      compare_mem();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
